// File: rtl/address_decoder.sv
// Classifies processor addresses into data RAM, video RAM, soft-reset control or unmapped space.
// One-cycle registered decode, one decode per cycle; no handshake, so it never stalls.
module address_decoder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_WORDS  = 64,
    parameter int VIDEO_WORDS = 254000,
    parameter int RESET_ADDR  = DATA_WORDS + VIDEO_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] MemAddr,
    output logic              DSel,
    output logic              reset,
    output logic [1:0]        WEn,
    output logic [ADDR_W-1:0] dAddr
);

    localparam logic [ADDR_W-1:0] VIDEO_BASE = ADDR_W'(DATA_WORDS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR  = ADDR_W'(RESET_ADDR);

    typedef enum logic [1:0] {
        REGION_DATA,
        REGION_VIDEO,
        REGION_CTRL,
        REGION_NONE
    } region_t;

    region_t           region;
    logic              dsel_nxt;
    logic              reset_nxt;
    logic [1:0]        wen_nxt;
    logic [ADDR_W-1:0] daddr_nxt;

    always_comb begin
        region = REGION_NONE;
        if (MemAddr < VIDEO_BASE) begin
            region = REGION_DATA;
        end else if (MemAddr < CTRL_ADDR) begin
            region = REGION_VIDEO;
        end else if (MemAddr == CTRL_ADDR) begin
            region = REGION_CTRL;
        end
    end

    // Writes to the control word and unmapped space never reach a memory.
    always_comb begin
        dsel_nxt  = 1'b0;
        reset_nxt = 1'b0;
        wen_nxt   = 2'b00;
        daddr_nxt = '0;
        unique case (region)
            REGION_DATA: begin
                wen_nxt   = {1'b0, MemWrite};
                daddr_nxt = MemAddr;
            end
            REGION_VIDEO: begin
                dsel_nxt  = 1'b1;
                wen_nxt   = {MemWrite, 1'b0};
                daddr_nxt = MemAddr - VIDEO_BASE;
            end
            REGION_CTRL: begin
                reset_nxt = 1'b1;
            end
            default: begin
                dsel_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            DSel  <= 1'b0;
            reset <= 1'b0;
            WEn   <= 2'b00;
            dAddr <= '0;
        end else begin
            DSel  <= dsel_nxt;
            reset <= reset_nxt;
            WEn   <= wen_nxt;
            dAddr <= daddr_nxt;
        end
    end

endmodule

// File: tb/tb_address_decoder.sv
// Directed and randomized decode checks against an arithmetic reference of the memory map.
module tb_address_decoder;

    localparam longint DATA_WORDS  = 64;
    localparam longint VIDEO_WORDS = 254000;
    localparam longint RESET_ADDR  = DATA_WORDS + VIDEO_WORDS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic        DSel;
    logic        reset;
    logic [1:0]  WEn;
    logic [31:0] dAddr;

    int tests_run = 0;
    int tests_failed = 0;

    address_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemWrite (MemWrite),
        .MemAddr  (MemAddr),
        .DSel     (DSel),
        .reset    (reset),
        .WEn      (WEn),
        .dAddr    (dAddr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dsel;
        logic        rst;
        logic [1:0]  wen;
        logic [31:0] daddr;
    } expect_t;

    // Reference: region by plain integer ranges, offsets by ordinary subtraction.
    function automatic expect_t model(input logic rn, input logic [31:0] addr, input logic wr);
        expect_t e;
        longint  a;
        e = '0;
        a = longint'(addr);
        if (rn) begin
            if (a < DATA_WORDS) begin
                e.daddr = addr;
                e.wen   = wr ? 2'd1 : 2'd0;
            end else if (a < DATA_WORDS + VIDEO_WORDS) begin
                e.dsel  = 1'b1;
                e.daddr = 32'(a - DATA_WORDS);
                e.wen   = wr ? 2'd2 : 2'd0;
            end else if (a == RESET_ADDR) begin
                e.rst   = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, then compare all outputs 1 time unit after the edge.
    task automatic step(input logic rn, input logic [31:0] addr, input logic wr, input string tag);
        expect_t e;
        rst_n    = rn;
        MemAddr  = addr;
        MemWrite = wr;
        e = model(rn, addr, wr);
        @(posedge clk);
        #1;
        check({tag, ".DSel"},  32'(DSel),  32'(e.dsel));
        check({tag, ".reset"}, 32'(reset), 32'(e.rst));
        check({tag, ".WEn"},   32'(WEn),   32'(e.wen));
        check({tag, ".dAddr"}, dAddr,      e.daddr);
        check({tag, ".WEn11"}, 32'(WEn == 2'b11), 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        int          sel;

        rst_n = 1'b0;
        MemWrite = 1'b0;
        MemAddr = '0;
        #2;

        step(1'b0, 32'd100, 1'b1, "reset_state");

        step(1'b1, 32'd0,  1'b0, "data_rd0");
        step(1'b1, 32'd0,  1'b1, "data_wr0");
        step(1'b1, 32'd63, 1'b0, "data_rd63");
        step(1'b1, 32'd63, 1'b1, "data_wr63");

        step(1'b1, 32'd64,     1'b0, "video_rd64");
        step(1'b1, 32'd64,     1'b1, "video_wr64");
        step(1'b1, 32'd254063, 1'b0, "video_rd_last");
        step(1'b1, 32'd254063, 1'b1, "video_wr_last");

        step(1'b1, 32'd254064, 1'b0, "ctrl_rd");
        step(1'b1, 32'd254064, 1'b1, "ctrl_wr");
        step(1'b1, 32'd254064, 1'b1, "ctrl_hold");

        step(1'b1, 32'd254065,    1'b0, "unmap_rd");
        step(1'b1, 32'd254065,    1'b1, "unmap_wr");
        step(1'b1, 32'hFFFF_FFFF, 1'b0, "unmap_max_rd");
        step(1'b1, 32'hFFFF_FFFF, 1'b1, "unmap_max_wr");

        step(1'b1, 32'd100, 1'b1, "pre_rst");
        step(1'b0, 32'd100, 1'b1, "mid_rst");
        step(1'b1, 32'd100, 1'b1, "post_rst");
        step(1'b1, 32'd100, 1'b0, "wr_toggle");

        step(1'b1, 32'd63,     1'b1, "b2b_63");
        step(1'b1, 32'd64,     1'b1, "b2b_64");
        step(1'b1, 32'd254063, 1'b1, "b2b_254063");
        step(1'b1, 32'd254064, 1'b1, "b2b_254064");
        step(1'b1, 32'd254065, 1'b1, "b2b_254065");

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: addr = 32'($urandom_range(0, 63));
                1: addr = 32'($urandom_range(64, 254063));
                2: addr = 32'(RESET_ADDR) + 32'($urandom_range(0, 4)) - 32'd2;
                3: addr = 32'd64 + 32'($urandom_range(0, 3)) - 32'd2;
                default: addr = $urandom;
            endcase
            step(($urandom_range(0, 15) != 0), addr, 1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
